// File: rtl/bitstream_counter_seq_if.sv
// Result stream toward the readout FIFO: one word per m_valid && m_ready handshake,
// with m_last marking the final word of each burst.
interface bitstream_counter_seq_if #(
  parameter int unsigned P_N_WIDTH = 32
);
  logic [P_N_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bitstream_counter_seq.sv
// Run controller and readout sequencer for one bitstream_counter instance.
// Define BITSTREAM_COUNTER_SEQ_HDR_EN to prefix each burst with a win_cnt header word.
module bitstream_counter_seq #(
  parameter int unsigned P_N_WIDTH   = 32,
  parameter int unsigned P_WIN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [P_N_WIDTH-1:0]   cfg_period,
  input  logic [P_N_WIDTH-1:0]   cfg_n_self_inh,
  input  logic [P_WIN_WIDTH-1:0] cfg_n_windows,
  output logic [P_N_WIDTH-1:0]   period,
  output logic [P_N_WIDTH-1:0]   n_self_inh,
  output logic                   cnt_rst,
  input  logic                   update,
  input  logic                   valid,
  input  logic [P_N_WIDTH-1:0]   n_pedge,
  input  logic [P_N_WIDTH-1:0]   n_nedge,
  input  logic [P_N_WIDTH-1:0]   n_high,
  input  logic [P_N_WIDTH-1:0]   n_low,
  bitstream_counter_seq_if.master m_if,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [P_WIN_WIDTH-1:0] win_cnt
);

`ifdef BITSTREAM_COUNTER_SEQ_HDR_EN
  localparam int unsigned LP_WORDS = 5;
`else
  localparam int unsigned LP_WORDS = 4;
`endif
  localparam int unsigned LP_IDX_W = 3;
  localparam logic [LP_IDX_W-1:0] LP_LAST_IDX = LP_IDX_W'(LP_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WARM, S_RUN, S_SEND} state_e;

  state_e                                 state_q, state_d;
  logic                                   arm_q, arm_d;
  logic [LP_IDX_W-1:0]                    idx_q, idx_d;
  logic [LP_WORDS-1:0][P_N_WIDTH-1:0]     hold_q, hold_d;
  logic [P_N_WIDTH-1:0]                   period_q, period_d;
  logic [P_N_WIDTH-1:0]                   n_self_inh_q, n_self_inh_d;
  logic [P_WIN_WIDTH-1:0]                 n_windows_q, n_windows_d;
  logic [P_WIN_WIDTH-1:0]                 win_cnt_q, win_cnt_d;
  logic [P_WIN_WIDTH-1:0]                 win_inc;
  logic                                   cnt_rst_q, cnt_rst_d;
  logic                                   m_valid_q, m_valid_d;
  logic                                   m_last_q, m_last_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   overrun_q, overrun_d;
  logic                                   hs;

  assign hs      = m_valid_q && m_if.m_ready;
  assign win_inc = win_cnt_q + P_WIN_WIDTH'(1);

  // Next-state, datapath and output decode; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    period_d     = period_q;
    n_self_inh_d = n_self_inh_q;
    n_windows_d  = n_windows_q;
    win_cnt_d    = win_cnt_q;
    cnt_rst_d    = cnt_rst_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;

    if (abort) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      cnt_rst_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            period_d     = cfg_period;
            n_self_inh_d = cfg_n_self_inh;
            n_windows_d  = cfg_n_windows;
            win_cnt_d    = '0;
            overrun_d    = 1'b0;
            cnt_rst_d    = 1'b1;
            arm_d        = 1'b0;
            state_d      = S_ARM;
          end
        end
        S_ARM: begin
          if (arm_q) begin
            cnt_rst_d = 1'b0;
            state_d   = S_WARM;
          end else begin
            arm_d = 1'b1;
          end
        end
        S_WARM: begin
          if (update) state_d = S_RUN;
        end
        S_RUN: begin
          if (update && valid) begin
`ifdef BITSTREAM_COUNTER_SEQ_HDR_EN
            hold_d[0] = P_N_WIDTH'(win_cnt_q);
            hold_d[1] = n_pedge;
            hold_d[2] = n_nedge;
            hold_d[3] = n_high;
            hold_d[4] = n_low;
`else
            hold_d[0] = n_pedge;
            hold_d[1] = n_nedge;
            hold_d[2] = n_high;
            hold_d[3] = n_low;
`endif
            idx_d     = '0;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            state_d   = S_SEND;
          end
        end
        S_SEND: begin
          // A window completing while a burst is still draining is lost.
          if (update) overrun_d = 1'b1;
          if (hs) begin
            if (idx_q == LP_LAST_IDX) begin
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
              win_cnt_d = win_inc;
              if ((n_windows_q != '0) && (win_inc == n_windows_q)) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_RUN;
              end
            end else begin
              hold_d   = hold_q >> P_N_WIDTH;
              idx_d    = idx_q + LP_IDX_W'(1);
              m_last_d = ((idx_q + LP_IDX_W'(1)) == LP_LAST_IDX);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      arm_q        <= 1'b0;
      idx_q        <= '0;
      hold_q       <= '0;
      period_q     <= '0;
      n_self_inh_q <= '0;
      n_windows_q  <= '0;
      win_cnt_q    <= '0;
      cnt_rst_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      period_q     <= period_d;
      n_self_inh_q <= n_self_inh_d;
      n_windows_q  <= n_windows_d;
      win_cnt_q    <= win_cnt_d;
      cnt_rst_q    <= cnt_rst_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign period      = period_q;
  assign n_self_inh  = n_self_inh_q;
  assign cnt_rst     = cnt_rst_q;
  assign m_if.m_data = hold_q[0];
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_last = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign win_cnt     = win_cnt_q;

endmodule
